wb_sram_slave: RTL and testbench
================================

# wb_sram_slave

Wishbone classic (B3) slave that answers the CPU's instruction-fetch and data-memory masters and drives one asynchronous external SRAM bank. It is the responder end of the masters' bus. It turns each single `cyc`/`stb` transaction into a timed SRAM read or write sequence with programmable wait states, then returns exactly one `ack` per accepted transfer. One instance sits behind each master port, or behind a shared arbiter.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 32: Wishbone address width.
- `DATA_WIDTH`, default 32: Wishbone data width. Must equal `SRAM_DATA_WIDTH`.
- `SRAM_ADDR_WIDTH`, default 20: SRAM word-address width.
- `SRAM_DATA_WIDTH`, default 32: SRAM data width.
- `READ_WAIT`, default 1: cycles `oe_n` is held low before data capture. Must be ≥1.
- `WRITE_WAIT`, default 1: width of the `we_n` low pulse in cycles. Must be ≥1.

**Ports**
- `clk` input 1: the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `wb_cyc_i` input 1: bus cycle.
- `wb_stb_i` input 1: strobe.
- `wb_ack_o` output 1: transfer acknowledge.
- `wb_adr_i` input ADDR_WIDTH: byte address.
- `wb_dat_i` input DATA_WIDTH: write data.
- `wb_dat_o` output DATA_WIDTH: read data.
- `wb_sel_i` input DATA_WIDTH/8: byte enables.
- `wb_we_i` input 1: 1 = write.
- `sram_addr` output SRAM_ADDR_WIDTH: SRAM word address.
- `sram_data_o` output SRAM_DATA_WIDTH: data driven to the SRAM.
- `sram_data_i` input SRAM_DATA_WIDTH: data from the SRAM.
- `sram_data_oe` output 1: tri-state enable for `sram_data_o`.
- `sram_ce_n` output 1: chip enable, active-low.
- `sram_oe_n` output 1: output enable, active-low.
- `sram_we_n` output 1: write enable, active-low.
- `sram_be_n` output SRAM_DATA_WIDTH/8: byte enables, active-low.

## Operation

- **Reset values:** `wb_ack_o`=0, `wb_dat_o`=0, `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=all 1, `sram_data_oe`=0, `sram_addr`=0, `sram_data_o`=0, state=IDLE.
- **Address mapping:** `sram_addr` = `wb_adr_i[SRAM_ADDR_WIDTH+1:2]`. Address bits [1:0] are ignored; byte lanes are selected only by `sel`.
- **IDLE:** when `cyc&stb` is seen, register address, write data, `~sel` and `we`. Go to RD if `we`=0, otherwise WR_SETUP.
- **RD:** `ce_n`=0, `oe_n`=0, `be_n`=`~sel`. Stay `READ_WAIT` cycles. On the last RD cycle, register `sram_data_i` into `wb_dat_o`. Go to ACK.
- **WR_SETUP:** lasts 1 cycle. `ce_n`=0, `data_oe`=1, `we_n`=1.
- **WR_PULSE:** lasts `WRITE_WAIT` cycles. As WR_SETUP, but with `we_n`=0.
- **WR_HOLD:** lasts 1 cycle. `we_n`=1, data still driven. Go to ACK.
- **ACK:** `wb_ack_o` = `wb_cyc_i & wb_stb_i`, high for one cycle only. All SRAM strobes are inactive and `data_oe`=0. Go to IDLE.
- **No back-to-back accept:** a new request is sampled no earlier than the IDLE cycle after ACK.
- **Master abort (`cyc` low mid-transfer):**
  - A read returns to IDLE on the next edge and its strobes deassert immediately. `wb_dat_o` keeps its old value.
  - A write runs its SETUP/PULSE/HOLD sequence to completion, so the SRAM is never left with a truncated `we_n` pulse. It then passes through ACK with no ack asserted.
- **Zero byte enables:** `sel`=0 runs a full cycle with `be_n` all 1, is acked normally, and writes nothing.
- **Read data hold:** `wb_dat_o` is only updated on read capture and is held otherwise.
- **Reset mid-transfer:** asynchronously forces all outputs to their reset values. No ack is issued.

## Timing

- Request first seen high in cycle 0.
- **Read:** ack in cycle `READ_WAIT+1` (cycle 2 with defaults).
- **Write:** ack in cycle `WRITE_WAIT+3` (cycle 4 with defaults).
- Throughput:
  - Reads: one transfer per `READ_WAIT+2` cycles.
  - Writes: one transfer per `WRITE_WAIT+4` cycles.
- All SRAM outputs are registered, so no combinational path runs from Wishbone inputs to SRAM pins.
- `wb_ack_o` is the one output gated combinationally, by `cyc&stb` in the ACK state.
- `sram_addr`, `be_n` and `data_o` are stable from the first RD/WR_SETUP cycle through the last RD/WR_HOLD cycle.

## Structure

- **Shared package `sram_ctrl_pkg`:**
  - State enum `sram_state_t` with values IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
  - Width-check functions.
  - Elaboration-time assertion that `READ_WAIT`≥1, `WRITE_WAIT`≥1 and `DATA_WIDTH`==`SRAM_DATA_WIDTH`.
- **Sub-module `sram_wait_timer`:** a loadable down-counter with `load`, `value` and `done` ports, shared by RD and WR_PULSE. Its width is `$clog2(max(READ_WAIT,WRITE_WAIT)+1)`.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles → all outputs at reset values and `ce_n`=1.
- **Read:** read `adr`=0x8000_0010, `sel`=0xF, SRAM model returns 0xDEADBEEF → `sram_addr`=0x4, `oe_n` low for 1 cycle, ack in cycle 2, `wb_dat_o`=0xDEADBEEF.
- **Byte write:** write `adr`=0x0000_0008, `dat`=0x1234_5678, `sel`=0x3 → `be_n`=0xC, `we_n` low exactly 1 cycle, `data_oe` high in cycles 1-3, ack in cycle 4; read-back gives 0x????5678 with the upper bytes unchanged.
- **Abort:** drop `cyc` in cycle 1 of a read → strobes high in cycle 2, no ack. Drop `cyc` in cycle 1 of a write → full `we_n` pulse still occurs, no ack.
- **Wait states:** `READ_WAIT`=3, `WRITE_WAIT`=2 → read ack in cycle 4, write ack in cycle 5, `we_n` low for 2 cycles.
- **Async reset:** assert `reset` during WR_PULSE → `we_n`, `ce_n` and `data_oe` reach inactive levels without waiting for a clock edge; next request completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state type and parameter helpers for the SRAM slave
package sram_ctrl_pkg;

   // Transfer sequencer states; RD serves reads, WR_* frame the write strobe.
   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      ACK
   } sram_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The wait timer only ever holds (wait - 1), but sizing to max+1 keeps
   // the one-cycle case at a legal one-bit width.
   function automatic int wait_timer_width(input int read_wait, input int write_wait);
      return $clog2(max_int(read_wait, write_wait) + 1);
   endfunction

   // Wait counts below one would collapse the strobe; the data path has no
   // width conversion, so both sides must match and be whole bytes.
   function automatic bit params_ok(input int read_wait, input int write_wait,
                                    input int data_width, input int sram_data_width);
      return (read_wait >= 1) && (write_wait >= 1) &&
             (data_width == sram_data_width) && ((data_width % 8) == 0);
   endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// rtl/sram_wait_timer.sv - loadable down-counter timing SRAM wait states
module sram_wait_timer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Load the remaining cycle count, then count down and park at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   // Zero means the current cycle is the last one of the timed phase.
   assign done = (count == '0);

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone classic slave driving an asynchronous SRAM bank
module wb_sram_slave
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int SRAM_DATA_WIDTH = 32,
   parameter int READ_WAIT       = 1,
   parameter int WRITE_WAIT      = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wb_cyc_i,
   input  logic                         wb_stb_i,
   output logic                         wb_ack_o,
   input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
   input  logic [DATA_WIDTH-1:0]        wb_dat_i,
   output logic [DATA_WIDTH-1:0]        wb_dat_o,
   input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
   input  logic                         wb_we_i,
   output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
   input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
   output logic                         sram_data_oe,
   output logic                         sram_ce_n,
   output logic                         sram_oe_n,
   output logic                         sram_we_n,
   output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

   localparam int TIMER_W = wait_timer_width(READ_WAIT, WRITE_WAIT);

   if (!params_ok(READ_WAIT, WRITE_WAIT, DATA_WIDTH, SRAM_DATA_WIDTH)) begin : g_bad_params
      $error("wb_sram_slave: READ_WAIT/WRITE_WAIT must be >= 1 and DATA_WIDTH must equal SRAM_DATA_WIDTH");
   end

   sram_state_t          state;
   sram_state_t          state_nxt;
   logic                 accept;
   logic                 capture;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_done;
   logic                 wr_busy;
   logic                 wr_aborted;
   logic                 nxt_active;
   logic                 nxt_wr;
   logic                 unused_adr_bits;

   // Word addressing: the low two address bits never reach the SRAM and
   // the bits above the SRAM window are don't-care.
   assign unused_adr_bits = ^wb_adr_i;

   assign accept  = (state == IDLE) && wb_cyc_i && wb_stb_i;
   assign wr_busy = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);

   sram_wait_timer #(
      .WIDTH (TIMER_W)
   ) u_wait_timer (
      .clk   (clk),
      .rst_n (reset),
      .load  (timer_load),
      .value (timer_value),
      .done  (timer_done)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus timer loads and the read-capture strobe.
   always_comb begin
      state_nxt   = state;
      timer_load  = 1'b0;
      timer_value = '0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (wb_we_i) begin
                  state_nxt = WR_SETUP;
               end else begin
                  state_nxt   = RD;
                  timer_load  = 1'b1;
                  timer_value = TIMER_W'(READ_WAIT - 1);
               end
            end
         end
         RD: begin
            // A read can be abandoned at once; nothing on the SRAM is at risk.
            if (!wb_cyc_i) begin
               state_nxt = IDLE;
            end else if (timer_done) begin
               capture   = 1'b1;
               state_nxt = ACK;
            end
         end
         WR_SETUP: begin
            state_nxt   = WR_PULSE;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(WRITE_WAIT - 1);
         end
         WR_PULSE: begin
            if (timer_done) begin
               state_nxt = WR_HOLD;
            end
         end
         WR_HOLD: begin
            state_nxt = ACK;
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Remember a write whose master went away so its ACK slot stays silent
   // even if a fresh cycle has started by then.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_aborted <= 1'b0;
      end else if (state == IDLE) begin
         wr_aborted <= 1'b0;
      end else if (wr_busy && !wb_cyc_i) begin
         wr_aborted <= 1'b1;
      end
   end

   assign nxt_active = (state_nxt == RD) || (state_nxt == WR_SETUP) ||
                       (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
   assign nxt_wr     = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                       (state_nxt == WR_HOLD);

   // SRAM pins come straight from flops keyed on the upcoming state, so the
   // strobes line up with the state they belong to without a comb path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_data_oe <= 1'b0;
         sram_be_n    <= '1;
         sram_addr    <= '0;
         sram_data_o  <= '0;
      end else begin
         sram_ce_n    <= !nxt_active;
         sram_oe_n    <= (state_nxt != RD);
         sram_we_n    <= (state_nxt != WR_PULSE);
         sram_data_oe <= nxt_wr;
         if (accept) begin
            sram_addr   <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
            sram_data_o <= wb_dat_i;
            sram_be_n   <= ~wb_sel_i;
         end else if (!nxt_active) begin
            sram_be_n <= '1;
         end
      end
   end

   // Read data is taken only on the final RD cycle and held otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_dat_o <= '0;
      end else if (capture) begin
         wb_dat_o <= sram_data_i;
      end
   end

   assign wb_ack_o = (state == ACK) && wb_cyc_i && wb_stb_i && !wr_aborted;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - randomized scoreboard bench for wb_sram_slave
`timescale 1ns/1ps
module tb_wb_sram_slave;

   typedef struct {
      int          idx;
      bit          is_rd;
      logic [31:0] data;
      int          ack_cyc;
   } sb_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cnt   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 1;

   logic        cyc [2];
   logic        stb [2];
   logic        we [2];
   logic        ack [2];
   logic        ce_n [2];
   logic        oe_n [2];
   logic        we_n [2];
   logic        doe [2];
   logic [31:0] adr [2];
   logic [31:0] dat_w [2];
   logic [31:0] dat_r [2];
   logic [31:0] sdo [2];
   logic [31:0] sdi [2];
   logic [3:0]  sel [2];
   logic [3:0]  be_n [2];
   logic [19:0] saddr [2];

   logic [31:0] smem [2][256];
   logic [31:0] ref_mem [2][256];
   logic [19:0] exp_addr [2];
   logic [3:0]  exp_be [2];
   logic [31:0] last_rd [2];
   sb_t         sbq [$];

   int n_checks = 0;
   int n_fail   = 0;

   wb_sram_slave dut0 (
      .clk (clk), .reset (rst_n),
      .wb_cyc_i (cyc[0]), .wb_stb_i (stb[0]), .wb_ack_o (ack[0]),
      .wb_adr_i (adr[0]), .wb_dat_i (dat_w[0]), .wb_dat_o (dat_r[0]),
      .wb_sel_i (sel[0]), .wb_we_i (we[0]),
      .sram_addr (saddr[0]), .sram_data_o (sdo[0]), .sram_data_i (sdi[0]),
      .sram_data_oe (doe[0]), .sram_ce_n (ce_n[0]), .sram_oe_n (oe_n[0]),
      .sram_we_n (we_n[0]), .sram_be_n (be_n[0])
   );

   wb_sram_slave #(.READ_WAIT (3), .WRITE_WAIT (2)) dut1 (
      .clk (clk), .reset (rst_n),
      .wb_cyc_i (cyc[1]), .wb_stb_i (stb[1]), .wb_ack_o (ack[1]),
      .wb_adr_i (adr[1]), .wb_dat_i (dat_w[1]), .wb_dat_o (dat_r[1]),
      .wb_sel_i (sel[1]), .wb_we_i (we[1]),
      .sram_addr (saddr[1]), .sram_data_o (sdo[1]), .sram_data_i (sdi[1]),
      .sram_data_oe (doe[1]), .sram_ce_n (ce_n[1]), .sram_oe_n (oe_n[1]),
      .sram_we_n (we_n[1]), .sram_be_n (be_n[1])
   );

   function automatic int rwv(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int wwv(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   // Asynchronous SRAM: drives the addressed word only while ce_n and oe_n are low.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         sdi[i] = (!ce_n[i] && !oe_n[i]) ? smem[i][saddr[i][7:0]] : 32'hA5A5_A5A5;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard on ack, pin-level strobe checks, and SRAM write commit.
   initial begin
      int          oe_run [2];
      int          we_run [2];
      int          doe_run [2];
      logic        prev_ce [2];
      logic [31:0] wr_data [2];
      logic [19:0] wr_addr [2];
      logic [3:0]  wr_be [2];
      sb_t         e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               oe_run[i]  = 0;
               we_run[i]  = 0;
               doe_run[i] = 0;
               prev_ce[i] = 1'b1;
               last_rd[i] = 32'h0;
            end else begin
               if (ack[i]) begin
                  if (sbq.size() == 0 || sbq[0].idx != i) begin
                     chk($sformatf("spurious_ack[%0d]", i), 32'd1, 32'd0);
                  end else begin
                     e = sbq.pop_front();
                     chk($sformatf("ack_cycle[%0d]", i), cnt, e.ack_cyc);
                     if (e.is_rd) begin
                        chk($sformatf("rd_data[%0d]", i), dat_r[i], e.data);
                        last_rd[i] = e.data;
                     end else begin
                        chk($sformatf("dat_o_hold[%0d]", i), dat_r[i], last_rd[i]);
                     end
                  end
               end
               if (!ce_n[i] && prev_ce[i]) begin
                  chk($sformatf("sram_addr[%0d]", i), {12'h0, saddr[i]}, {12'h0, exp_addr[i]});
                  chk($sformatf("be_n[%0d]", i), {28'h0, be_n[i]}, {28'h0, exp_be[i]});
               end
               prev_ce[i] = ce_n[i];
               if (!oe_n[i]) begin
                  oe_run[i]++;
               end else if (oe_run[i] > 0) begin
                  chk($sformatf("oe_width[%0d]", i), oe_run[i], rwv(i));
                  oe_run[i] = 0;
               end
               if (!we_n[i]) begin
                  we_run[i]++;
                  wr_addr[i] = saddr[i];
                  wr_data[i] = sdo[i];
                  wr_be[i]   = be_n[i];
               end else if (we_run[i] > 0) begin
                  chk($sformatf("we_width[%0d]", i), we_run[i], wwv(i));
                  for (int b = 0; b < 4; b++) begin
                     if (!wr_be[i][b]) smem[i][wr_addr[i][7:0]][8*b +: 8] = wr_data[i][8*b +: 8];
                  end
                  we_run[i] = 0;
               end
               if (doe[i]) begin
                  doe_run[i]++;
               end else if (doe_run[i] > 0) begin
                  chk($sformatf("doe_width[%0d]", i), doe_run[i], wwv(i) + 2);
                  doe_run[i] = 0;
               end
            end
         end
      end
   end

   // One Wishbone transfer; abort_at>0 drops cyc in that cycle, keep holds
   // cyc/stb after ack so the next call lands in the cycle right after ACK.
   task automatic xfer(input int idx, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int abort_at, input bit keep);
      sb_t         e;
      logic [7:0]  wd;
      logic [31:0] nw;
      bit          got;
      @(posedge clk);
      #1;
      cyc[idx] = 1'b1; stb[idx] = 1'b1; we[idx] = w;
      adr[idx] = a; dat_w[idx] = d; sel[idx] = s;
      exp_addr[idx] = a[21:2];
      exp_be[idx]   = ~s;
      wd = a[9:2];
      nw = ref_mem[idx][wd];
      for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
      if (w) ref_mem[idx][wd] = nw;
      e.idx     = idx;
      e.is_rd   = !w;
      e.data    = w ? 32'h0 : ref_mem[idx][wd];
      e.ack_cyc = cnt + (w ? wwv(idx) + 3 : rwv(idx) + 1);
      if (abort_at > 0) begin
         repeat (abort_at) @(posedge clk);
         #1;
         cyc[idx] = 1'b0; stb[idx] = 1'b0;
         repeat (8) @(posedge clk);
      end else begin
         sbq.push_back(e);
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = ack[idx];
         end
         chk($sformatf("ack_seen[%0d]", idx), {31'h0, got}, 32'd1);
         if (!got) sbq.delete();
         if (!keep || !got) begin
            @(posedge clk);
            #1;
            cyc[idx] = 1'b0; stb[idx] = 1'b0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] old;
      for (int i = 0; i < 2; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
         adr[i] = '0; dat_w[i] = '0; sel[i] = '0;
         exp_addr[i] = '0; exp_be[i] = '0;
         for (int w = 0; w < 256; w++) begin
            smem[i][w]    = $urandom();
            ref_mem[i][w] = smem[i][w];
         end
      end
      smem[0][4]    = 32'hDEAD_BEEF;
      ref_mem[0][4] = 32'hDEAD_BEEF;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_ack[%0d]", i), {31'h0, ack[i]}, 32'd0);
         chk($sformatf("rst_dat_o[%0d]", i), dat_r[i], 32'h0);
         chk($sformatf("rst_ce_n[%0d]", i), {31'h0, ce_n[i]}, 32'd1);
         chk($sformatf("rst_oe_n[%0d]", i), {31'h0, oe_n[i]}, 32'd1);
         chk($sformatf("rst_we_n[%0d]", i), {31'h0, we_n[i]}, 32'd1);
         chk($sformatf("rst_be_n[%0d]", i), {28'h0, be_n[i]}, 32'hF);
         chk($sformatf("rst_doe[%0d]", i), {31'h0, doe[i]}, 32'd0);
         chk($sformatf("rst_addr[%0d]", i), {12'h0, saddr[i]}, 32'h0);
         chk($sformatf("rst_data_o[%0d]", i), sdo[i], 32'h0);
      end
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Directed: read, byte write and read-back, zero-sel write.
      xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 1'b0);
      xfer(0, 1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 0, 1'b0);
      old = ref_mem[0][2];
      chk("byte_write_model", old[15:0], 32'h5678);
      xfer(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 0, 1'b0);
      xfer(0, 1'b1, 32'h0000_001C, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
      xfer(0, 1'b0, 32'h0000_001C, 32'h0, 4'hF, 0, 1'b0);

      // Master aborts: read drops without ack, write still pulses fully.
      xfer(0, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 1, 1'b0);
      chk("abort_rd_hold", dat_r[0], last_rd[0]);
      chk("abort_rd_ce_n", {31'h0, ce_n[0]}, 32'd1);
      xfer(0, 1'b1, 32'h0000_0018, 32'hCAFE_F00D, 4'hF, 1, 1'b0);
      xfer(0, 1'b0, 32'h0000_0018, 32'h0, 4'hF, 0, 1'b0);

      // Wait-state instance.
      xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b0);
      xfer(1, 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hC, 0, 1'b0);
      xfer(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1'b0);

      // Back-to-back reads on both instances at full throughput.
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) xfer(i, 1'b0, 32'(k) << 2, 32'h0, 4'hF, 0, (k < 3));
      end

      // Asynchronous reset in the middle of the write pulse.
      @(posedge clk);
      #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
      adr[0] = 32'd200 << 2; dat_w[0] = 32'h5555_AAAA; sel[0] = 4'hF;
      exp_addr[0] = 20'd200; exp_be[0] = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("mid_pulse_we_n", {31'h0, we_n[0]}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_we_n", {31'h0, we_n[0]}, 32'd1);
      chk("async_ce_n", {31'h0, ce_n[0]}, 32'd1);
      chk("async_doe", {31'h0, doe[0]}, 32'd0);
      chk("async_ack", {31'h0, ack[0]}, 32'd0);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      xfer(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b0);

      // Randomized traffic in short same-instance bursts.
      for (int blk = 0; blk < 15; blk++) begin
         int i;
         i = $urandom_range(0, 1);
         for (int k = 0; k < 4; k++) begin
            a = ($urandom() & 32'hFFC0_0003) | (32'($urandom_range(0, 63)) << 2);
            xfer(i, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), 0, (k < 3));
         end
      end

      // Read back every word the random traffic could have touched.
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 64; w++) xfer(i, 1'b0, 32'(w) << 2, 32'h0, 4'hF, 0, (w < 63));
      end

      repeat (4) @(posedge clk);
      chk("sb_empty", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
